gba_cart_reader: RTL

GBA_CART_READER -- requirements
Module: gba_cart_reader

---
 rtl/gba_cart_reader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/gba_cart_reader.sv
// GBA cartridge ROM burst reader: non-sequential address phase, then sequential RD pulses.
// Optional running checksum output enabled by defining GBA_CART_READER_CHECKSUM_EN.
module gba_cart_reader #(
  parameter int ADDR_SETUP_CYC = 2,
  parameter int ADDR_HOLD_CYC  = 6,
  parameter int RD_LOW_CYC     = 8,
  parameter int RD_HIGH_CYC    = 4,
  parameter int CS_HIGH_CYC    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [8:0]  len,
  output logic        busy,
  output logic        done,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        GBACART_CS,
  output logic        GBACART_RD,
  output logic [7:0]  GBACART_AH,
  output logic [15:0] GBACART_AD_O,
  output logic        GBACART_AD_OE,
  input  logic [15:0] GBACART_AD_I
`ifdef GBA_CART_READER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  typedef enum logic [2:0] {IDLE, ASETUP, AHOLD, TURN, RDLO, RDHI, CSHI} state_t;

  localparam logic [7:0] SETUP_LAST = 8'(ADDR_SETUP_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(ADDR_HOLD_CYC - 1);
  localparam logic [7:0] RDLO_LAST  = 8'(RD_LOW_CYC - 1);
  localparam logic [7:0] RDHI_LAST  = 8'(RD_HIGH_CYC - 1);
  localparam logic [7:0] CSHI_LAST  = 8'(CS_HIGH_CYC - 1);

  logic [1:0]  rst_sync_reg;
  logic        rst_int_n;
  state_t      state_reg;
  logic [7:0]  cnt_reg;
  logic [23:0] cur_addr_reg;
  logic [8:0]  remaining_reg;
  logic [23:0] addr_inc;
  logic [8:0]  rem_dec;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_int_n = rst_sync_reg[1];

  assign addr_inc = cur_addr_reg + 24'd1;
  assign rem_dec  = remaining_reg - 9'd1;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      GBACART_CS    <= 1'b1;
      GBACART_RD    <= 1'b1;
      GBACART_AH    <= '0;
      GBACART_AD_O  <= '0;
      GBACART_AD_OE <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (len != 9'd0) begin
              state_reg     <= ASETUP;
              cnt_reg       <= '0;
              busy          <= 1'b1;
              cur_addr_reg  <= addr;
              remaining_reg <= len;
              GBACART_AD_OE <= 1'b1;
              GBACART_AD_O  <= addr[15:0];
              GBACART_AH    <= addr[23:16];
            end else begin
              done <= 1'b1;
            end
          end
        end
        ASETUP: begin
          if (cnt_reg == SETUP_LAST) begin
            state_reg  <= AHOLD;
            cnt_reg    <= '0;
            GBACART_CS <= 1'b0;
          end else cnt_reg <= cnt_reg + 8'd1;
        end
        AHOLD: begin
          if (cnt_reg == HOLD_LAST) begin
            state_reg     <= TURN;
            cnt_reg       <= '0;
            GBACART_AD_OE <= 1'b0;
          end else cnt_reg <= cnt_reg + 8'd1;
        end
        TURN: begin
          state_reg  <= RDLO;
          cnt_reg    <= '0;
          GBACART_RD <= 1'b0;
        end
        RDLO: begin
          if (cnt_reg == RDLO_LAST) begin
            state_reg  <= RDHI;
            cnt_reg    <= '0;
            rd_data    <= GBACART_AD_I;
            rd_valid   <= 1'b1;
            GBACART_RD <= 1'b1;
          end else cnt_reg <= cnt_reg + 8'd1;
        end
        RDHI: begin
          if (cnt_reg == RDHI_LAST) begin
            cnt_reg       <= '0;
            remaining_reg <= rem_dec;
            cur_addr_reg  <= addr_inc;
            // The cart's internal counter only spans 16 bits, so a low-half wrap needs a fresh address phase.
            if (rem_dec != 9'd0 && addr_inc[15:0] != 16'd0) begin
              state_reg  <= RDLO;
              GBACART_RD <= 1'b0;
            end else begin
              state_reg  <= CSHI;
              GBACART_CS <= 1'b1;
            end
          end else cnt_reg <= cnt_reg + 8'd1;
        end
        CSHI: begin
          if (cnt_reg == CSHI_LAST) begin
            cnt_reg <= '0;
            if (remaining_reg != 9'd0) begin
              state_reg     <= ASETUP;
              GBACART_AD_OE <= 1'b1;
              GBACART_AD_O  <= cur_addr_reg[15:0];
              GBACART_AH    <= cur_addr_reg[23:16];
            end else begin
              state_reg <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end else cnt_reg <= cnt_reg + 8'd1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef GBA_CART_READER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) checksum <= '0;
    else if (state_reg == IDLE && start) checksum <= '0;
    else if (rd_valid) checksum <= checksum + rd_data;
  end
`endif

endmodule
